mrv1_th_issue_mw: RTL and testbench

MRV1_TH_ISSUE_MW -- requirements
Module: mrv1_th_issue_mw

---
 rtl/mrv1_th_pkg.sv | 10 +
 rtl/mrv1_th_pick.sv | 48 ++++
 rtl/mrv1_th_issue_mw.sv | 120 ++++++++++++
 tb/tb_mrv1_th_issue_mw.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrv1_th_pkg.sv
// Shared types for the multi-wide thread issue scheduler.
package mrv1_th_pkg;

   // Scheduling policy selected by mode_i.
   typedef enum logic {
      TH_ISSUE_BATCH = 1'b0,
      TH_ISSUE_RR    = 1'b1
   } th_issue_mode_e;

endpackage

// File: rtl/mrv1_th_pick.sv
// Rotating-priority picker: grants up to W_P set bits of vec_i, searching
// upward from start_i and wrapping modulo N_P. The first hit lands on lane 0.
module mrv1_th_pick #(
   parameter int N_P = 8,
   parameter int W_P = 2,
   parameter int T_P = $clog2(N_P)
) (
   input  logic [N_P-1:0]     vec_i,
   input  logic [T_P-1:0]     start_i,
   output logic [W_P-1:0]     vld_o,
   output logic [W_P*T_P-1:0] tid_o
);

   logic [T_P:0]   w_back_sh;
   logic [N_P-1:0] w_rot;

   // Rotate so that bit start_i becomes bit 0; the search is then a plain
   // ascending scan over w_rot. A shift by N_P (start_i == 0) yields zero.
   assign w_back_sh = (T_P+1)'(N_P) - {1'b0, start_i};
   assign w_rot     = (vec_i >> start_i) | (vec_i << w_back_sh);

   // Walk the rotated vector, placing each hit on the next free lane.
   always_comb begin
      int         cnt;
      logic [T_P:0] v_sum;
      vld_o = '0;
      tid_o = '0;
      cnt   = 0;
      v_sum = '0;
      for (int j = 0; j < N_P; j++) begin
         if (w_rot[j]) begin
            // Undo the rotation to recover the real thread id.
            v_sum = {1'b0, start_i} + (T_P+1)'(j);
            if (v_sum >= (T_P+1)'(N_P)) begin
               v_sum = v_sum - (T_P+1)'(N_P);
            end
            for (int k = 0; k < W_P; k++) begin
               if (k == cnt) begin
                  vld_o[k]           = 1'b1;
                  tid_o[k*T_P +: T_P] = v_sum[T_P-1:0];
               end
            end
            cnt = cnt + 1;
         end
      end
   end

endmodule

// File: rtl/mrv1_th_issue_mw.sv
// Multi-wide thread issue scheduler. BATCH mode snapshots the ready set into
// a table and drains it lowest-tid first before admitting new threads; RR
// mode issues from the live ready set starting at a rotating pointer.
module mrv1_th_issue_mw
   import mrv1_th_pkg::*;
#(
   parameter int NUM_TW_P      = 8,
   parameter int ISSUE_WIDTH_P = 2,
   parameter int tid_width_lp  = $clog2(NUM_TW_P)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_TW_P-1:0]                 issue_rdy_i,
   input  logic [NUM_TW_P-1:0]                 kill_i,
   input  logic                                stall_i,
   input  logic                                mode_i,
   output logic [ISSUE_WIDTH_P-1:0]            issue_vld_o,
   output logic [ISSUE_WIDTH_P*tid_width_lp-1:0] issue_tid_o,
   output logic [$clog2(ISSUE_WIDTH_P+1)-1:0]  issue_cnt_o
);

   localparam int CNT_W = $clog2(ISSUE_WIDTH_P+1);
   localparam int T_W   = tid_width_lp;

   logic [NUM_TW_P-1:0]            r_table;
   logic [T_W-1:0]                 r_rr_ptr;

   th_issue_mode_e                 w_mode;
   logic [NUM_TW_P-1:0]            w_live;
   logic [NUM_TW_P-1:0]            w_fresh;
   logic [NUM_TW_P-1:0]            w_cand;
   logic [T_W-1:0]                 w_start;
   logic [ISSUE_WIDTH_P-1:0]       w_pick_vld;
   logic [ISSUE_WIDTH_P*T_W-1:0]   w_pick_tid;
   logic [NUM_TW_P-1:0]            w_grant_mask;
   logic [T_W-1:0]                 w_last_tid;
   logic [T_W:0]                   w_last_inc;
   logic [T_W-1:0]                 w_ptr_next;
   logic [CNT_W-1:0]               w_cnt;
   logic                           w_block;

   assign w_mode  = th_issue_mode_e'(mode_i);
   assign w_live  = r_table & ~kill_i;
   assign w_fresh = issue_rdy_i & ~kill_i;
   assign w_block = rst_i | stall_i;

   // Choose the candidate set and search origin for the active policy.
   always_comb begin
      w_cand  = w_fresh;
      w_start = '0;
      if (w_mode == TH_ISSUE_RR) begin
         w_start = r_rr_ptr;
      end else if (w_live != '0) begin
         w_cand = w_live;
      end
   end

   mrv1_th_pick #(
      .N_P (NUM_TW_P),
      .W_P (ISSUE_WIDTH_P),
      .T_P (T_W)
   ) u_pick (
      .vec_i   (w_cand),
      .start_i (w_start),
      .vld_o   (w_pick_vld),
      .tid_o   (w_pick_tid)
   );

   // Summarise the picked lanes: grant mask, count and highest-lane tid.
   always_comb begin
      w_grant_mask = '0;
      w_last_tid   = '0;
      w_cnt        = '0;
      for (int k = 0; k < ISSUE_WIDTH_P; k++) begin
         if (w_pick_vld[k]) begin
            w_last_tid = w_pick_tid[k*T_W +: T_W];
            w_cnt      = w_cnt + CNT_W'(1);
         end
         for (int j = 0; j < NUM_TW_P; j++) begin
            if (w_pick_vld[k] && (w_pick_tid[k*T_W +: T_W] == T_W'(j))) begin
               w_grant_mask[j] = 1'b1;
            end
         end
      end
   end

   // Pointer moves just past the last granted tid, wrapping at NUM_TW_P.
   assign w_last_inc = {1'b0, w_last_tid} + (T_W+1)'(1);
   assign w_ptr_next = (w_last_inc == (T_W+1)'(NUM_TW_P)) ? '0 : w_last_inc[T_W-1:0];

   // Drive lanes only when neither reset nor stall blocks issue.
   always_comb begin
      issue_vld_o = '0;
      issue_tid_o = '0;
      issue_cnt_o = '0;
      if (!w_block) begin
         issue_vld_o = w_pick_vld;
         issue_tid_o = w_pick_tid;
         issue_cnt_o = w_cnt;
      end
   end

   // Table drains in BATCH and stays empty in RR; rr_ptr only moves on an RR grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_table  <= '0;
         r_rr_ptr <= '0;
      end else if (w_mode == TH_ISSUE_RR) begin
         r_table <= '0;
         if (!stall_i && (w_pick_vld != '0)) begin
            r_rr_ptr <= w_ptr_next;
         end
      end else if (stall_i) begin
         r_table <= w_live;
      end else begin
         r_table <= w_cand & ~w_grant_mask;
      end
   end

endmodule

// File: tb/tb_mrv1_th_issue_mw.sv
// Directed bench for mrv1_th_issue_mw at N=8, W=2. Lane outputs are compared
// as one packed word {vld[1:0], tid1, tid0, cnt}.
module tb_mrv1_th_issue_mw;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [7:0] issue_rdy_i = '0;
   logic [7:0] kill_i = '0;
   logic       stall_i = 1'b0;
   logic       mode_i = 1'b0;
   logic [1:0] issue_vld_o;
   logic [5:0] issue_tid_o;
   logic [1:0] issue_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   mrv1_th_issue_mw #(
      .NUM_TW_P      (8),
      .ISSUE_WIDTH_P (2)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .issue_rdy_i (issue_rdy_i),
      .kill_i      (kill_i),
      .stall_i     (stall_i),
      .mode_i      (mode_i),
      .issue_vld_o (issue_vld_o),
      .issue_tid_o (issue_tid_o),
      .issue_cnt_o (issue_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [9:0] pk(input logic [1:0] v, input logic [2:0] t1,
                                     input logic [2:0] t0, input logic [1:0] c);
      return {v, t1, t0, c};
   endfunction

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; kill_i = '0; stall_i = 1'b0; mode_i = 1'b0; issue_rdy_i = '0;
      next_cycle();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] got;
      rst_i = 1'b1; issue_rdy_i = 8'hFF;
      @(negedge clk_i);
      got = {issue_vld_o, issue_tid_o, issue_cnt_o};
      n_checks++;
      if (got !== 10'h000) begin
         n_errors++;
         $display("FAIL reset_outputs: got %h expected %h", got, 10'h000);
      end
      $display("reset: outputs %h", got);
      next_cycle();
      rst_i = 1'b0;
   endtask

   task automatic test_batch_drain();
      logic [9:0] exp_v [4];
      logic [9:0] got;
      exp_v[0] = pk(2'b11, 3'd2, 3'd1, 2'd2);
      exp_v[1] = pk(2'b11, 3'd5, 3'd4, 2'd2);
      exp_v[2] = pk(2'b01, 3'd0, 3'd7, 2'd1);
      exp_v[3] = pk(2'b11, 3'd2, 3'd1, 2'd2);
      do_reset();
      issue_rdy_i = 8'b1011_0110;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         got = {issue_vld_o, issue_tid_o, issue_cnt_o};
         n_checks++;
         if (got !== exp_v[c]) begin
            n_errors++;
            $display("FAIL batch_drain c%0d: got %h expected %h", c, got, exp_v[c]);
         end
         $display("batch_drain c%0d: out %h", c, got);
         next_cycle();
      end
   endtask

   task automatic test_batch_kill();
      logic [9:0] exp_v [3];
      logic [7:0] kill_v [3];
      logic [9:0] got;
      exp_v[0] = pk(2'b11, 3'd2, 3'd1, 2'd2); kill_v[0] = 8'h00;
      exp_v[1] = pk(2'b11, 3'd7, 3'd5, 2'd2); kill_v[1] = 8'h10;
      exp_v[2] = pk(2'b11, 3'd2, 3'd1, 2'd2); kill_v[2] = 8'h00;
      do_reset();
      issue_rdy_i = 8'b1011_0110;
      for (int c = 0; c < 3; c++) begin
         kill_i = kill_v[c];
         @(negedge clk_i);
         got = {issue_vld_o, issue_tid_o, issue_cnt_o};
         n_checks++;
         if (got !== exp_v[c]) begin
            n_errors++;
            $display("FAIL batch_kill c%0d: got %h expected %h", c, got, exp_v[c]);
         end
         $display("batch_kill c%0d: kill %h out %h", c, kill_i, got);
         next_cycle();
      end
      kill_i = '0;
   endtask

   task automatic test_stall();
      logic [9:0] exp_v [7];
      logic       st_v [7];
      logic [9:0] got;
      exp_v[0] = pk(2'b11, 3'd2, 3'd1, 2'd2); st_v[0] = 1'b0;
      exp_v[1] = 10'h000;                     st_v[1] = 1'b1;
      exp_v[2] = 10'h000;                     st_v[2] = 1'b1;
      exp_v[3] = 10'h000;                     st_v[3] = 1'b1;
      exp_v[4] = pk(2'b11, 3'd5, 3'd4, 2'd2); st_v[4] = 1'b0;
      exp_v[5] = pk(2'b01, 3'd0, 3'd7, 2'd1); st_v[5] = 1'b0;
      exp_v[6] = pk(2'b11, 3'd2, 3'd1, 2'd2); st_v[6] = 1'b0;
      do_reset();
      issue_rdy_i = 8'b1011_0110;
      for (int c = 0; c < 7; c++) begin
         stall_i = st_v[c];
         @(negedge clk_i);
         got = {issue_vld_o, issue_tid_o, issue_cnt_o};
         n_checks++;
         if (got !== exp_v[c]) begin
            n_errors++;
            $display("FAIL stall c%0d: got %h expected %h", c, got, exp_v[c]);
         end
         $display("stall c%0d: stall %0b out %h", c, stall_i, got);
         next_cycle();
      end
      stall_i = 1'b0;
   endtask

   task automatic test_rr_wrap();
      logic [9:0] exp_v [4];
      logic [7:0] rdy_v [4];
      logic [9:0] got;
      exp_v[0] = pk(2'b01, 3'd0, 3'd5, 2'd1); rdy_v[0] = 8'h20;
      exp_v[1] = pk(2'b11, 3'd7, 3'd6, 2'd2); rdy_v[1] = 8'hFF;
      exp_v[2] = pk(2'b11, 3'd1, 3'd0, 2'd2); rdy_v[2] = 8'hFF;
      exp_v[3] = pk(2'b11, 3'd3, 3'd2, 2'd2); rdy_v[3] = 8'hFF;
      do_reset();
      mode_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         issue_rdy_i = rdy_v[c];
         @(negedge clk_i);
         got = {issue_vld_o, issue_tid_o, issue_cnt_o};
         n_checks++;
         if (got !== exp_v[c]) begin
            n_errors++;
            $display("FAIL rr_wrap c%0d: got %h expected %h", c, got, exp_v[c]);
         end
         $display("rr_wrap c%0d: rdy %h out %h", c, issue_rdy_i, got);
         next_cycle();
      end
   endtask

   task automatic test_mode_switch();
      logic [9:0] exp_v [3];
      logic [7:0] rdy_v [3];
      logic       md_v [3];
      logic [9:0] got;
      exp_v[0] = pk(2'b11, 3'd2, 3'd1, 2'd2); rdy_v[0] = 8'b1011_0110; md_v[0] = 1'b0;
      exp_v[1] = pk(2'b11, 3'd3, 3'd0, 2'd2); rdy_v[1] = 8'h09;        md_v[1] = 1'b1;
      exp_v[2] = pk(2'b11, 3'd1, 3'd0, 2'd2); rdy_v[2] = 8'h03;        md_v[2] = 1'b0;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         issue_rdy_i = rdy_v[c];
         mode_i      = md_v[c];
         @(negedge clk_i);
         got = {issue_vld_o, issue_tid_o, issue_cnt_o};
         n_checks++;
         if (got !== exp_v[c]) begin
            n_errors++;
            $display("FAIL mode_switch c%0d: got %h expected %h", c, got, exp_v[c]);
         end
         $display("mode_switch c%0d: mode %0b out %h", c, mode_i, got);
         next_cycle();
      end
      mode_i = 1'b0;
   endtask

   task automatic test_reset_mid_batch();
      logic [9:0] exp_v [3];
      logic       rs_v [3];
      logic [9:0] got;
      exp_v[0] = pk(2'b11, 3'd2, 3'd1, 2'd2); rs_v[0] = 1'b0;
      exp_v[1] = 10'h000;                     rs_v[1] = 1'b1;
      exp_v[2] = pk(2'b11, 3'd2, 3'd1, 2'd2); rs_v[2] = 1'b0;
      do_reset();
      issue_rdy_i = 8'b1011_0110;
      for (int c = 0; c < 3; c++) begin
         rst_i = rs_v[c];
         @(negedge clk_i);
         got = {issue_vld_o, issue_tid_o, issue_cnt_o};
         n_checks++;
         if (got !== exp_v[c]) begin
            n_errors++;
            $display("FAIL reset_mid_batch c%0d: got %h expected %h", c, got, exp_v[c]);
         end
         $display("reset_mid_batch c%0d: rst %0b out %h", c, rst_i, got);
         next_cycle();
      end
      rst_i = 1'b0;
   endtask

   task automatic test_empty_and_hold();
      logic [9:0] exp_v [7];
      logic [7:0] rdy_v [7];
      logic [7:0] kl_v [7];
      logic       st_v [7];
      logic       md_v [7];
      logic [9:0] got;
      exp_v[0] = pk(2'b01, 3'd0, 3'd3, 2'd1); rdy_v[0] = 8'h08; kl_v[0] = 8'h00; st_v[0] = 1'b0; md_v[0] = 1'b1;
      exp_v[1] = 10'h000;                     rdy_v[1] = 8'h00; kl_v[1] = 8'h00; st_v[1] = 1'b0; md_v[1] = 1'b1;
      exp_v[2] = 10'h000;                     rdy_v[2] = 8'hFF; kl_v[2] = 8'h00; st_v[2] = 1'b1; md_v[2] = 1'b1;
      exp_v[3] = pk(2'b11, 3'd5, 3'd4, 2'd2); rdy_v[3] = 8'hFF; kl_v[3] = 8'h00; st_v[3] = 1'b0; md_v[3] = 1'b1;
      exp_v[4] = pk(2'b11, 3'd0, 3'd7, 2'd2); rdy_v[4] = 8'hFF; kl_v[4] = 8'h40; st_v[4] = 1'b0; md_v[4] = 1'b1;
      exp_v[5] = pk(2'b11, 3'd2, 3'd1, 2'd2); rdy_v[5] = 8'hFF; kl_v[5] = 8'h00; st_v[5] = 1'b0; md_v[5] = 1'b1;
      exp_v[6] = 10'h000;                     rdy_v[6] = 8'hF0; kl_v[6] = 8'hF0; st_v[6] = 1'b0; md_v[6] = 1'b0;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         issue_rdy_i = rdy_v[c];
         kill_i      = kl_v[c];
         stall_i     = st_v[c];
         mode_i      = md_v[c];
         @(negedge clk_i);
         got = {issue_vld_o, issue_tid_o, issue_cnt_o};
         n_checks++;
         if (got !== exp_v[c]) begin
            n_errors++;
            $display("FAIL empty_hold c%0d: got %h expected %h", c, got, exp_v[c]);
         end
         $display("empty_hold c%0d: rdy %h kill %h out %h", c, issue_rdy_i, kill_i, got);
         next_cycle();
      end
      kill_i = '0; stall_i = 1'b0; mode_i = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_batch_drain();
      test_batch_kill();
      test_stall();
      test_rr_wrap();
      test_mode_switch();
      test_reset_mid_batch();
      test_empty_and_hold();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
